// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: $4014 OAM DMA sequencer and CPU bus arbiter.
// Define OAM_DMA_ALIGN_EN to enable the parity ALIGN cycle.
module oam_dma_ctrl #(
  parameter int          RD_LAT   = 1,
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r,
  input  logic        cpu_w,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_r,
  output logic        bus_w,
  output logic [7:0]  bus_wdata,
  output logic        cpu_halt,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE, HALT, ALIGN, READ, WAIT, WRITE
  } state_t;

  localparam logic [1:0] WLAST = 2'(RD_LAT - 2);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  page;
  logic [7:0]  cnt;
  logic [7:0]  data;
  logic [1:0]  wcnt;
  logic        trig;
  logic        last;
  logic        cap;

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  // Free-running cycle parity used to pick the ALIGN slot.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) parity <= 1'b0;
    else        parity <= ~parity;
  end
`endif

  assign trig = (state == IDLE) && cpu_w
             && (cpu_addr == DMA_REG);
  assign last = (state == WRITE) && (cnt == 8'hFF);
  assign cap  = (RD_LAT == 1) ? (state == READ)
              : ((state == WAIT) && (wcnt == WLAST));

  // Next state and arbitrated bus drive.
  always_comb begin
    state_nx  = state;
    bus_addr  = '0;
    bus_r     = 1'b0;
    bus_w     = 1'b0;
    bus_wdata = '0;
    unique case (state)
      IDLE: begin
        bus_addr  = cpu_addr;
        bus_r     = cpu_r;
        bus_w     = cpu_w;
        bus_wdata = cpu_wdata;
        if (trig) state_nx = HALT;
      end
      HALT: begin
        state_nx = READ;
`ifdef OAM_DMA_ALIGN_EN
        if (parity) state_nx = ALIGN;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: state_nx = READ;
`endif
      READ: begin
        bus_addr = {page, cnt};
        bus_r    = 1'b1;
        state_nx = (RD_LAT == 1) ? WRITE : WAIT;
      end
      WAIT: begin
        if (wcnt == WLAST) state_nx = WRITE;
      end
      WRITE: begin
        bus_addr  = OAM_PORT;
        bus_w     = 1'b1;
        bus_wdata = data;
        state_nx  = last ? IDLE : READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered status flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      cpu_halt <= 1'b0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      state    <= state_nx;
      cpu_halt <= (state_nx != IDLE);
      dma_busy <= (state_nx != IDLE);
      dma_done <= last;
    end
  end

  // Source page, byte index, wait counter and data latch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      page <= '0;
      cnt  <= '0;
      wcnt <= '0;
      data <= '0;
    end else begin
      if (trig) begin
        page <= cpu_wdata;
        cnt  <= '0;
      end
      if ((state == WRITE) && !last) cnt <= cnt + 8'd1;
      if (state == READ)      wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + 2'd1;
      if (cap) data <= bus_rdata;
    end
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the $4014 OAM DMA transfer and arbitrates the CPU memory bus between the 6502 core and the DMA engine.
- A CPU write to $4014 latches a source page and halts the core. The block then copies 256 bytes from {page,00}..{page,FF} to the PPU OAMDATA port at $2004, and releases the core.
- Sits between the core's bus outputs and the memory/IO decode block.

Parameters:
- RD_LAT, 1, memory read latency in cycles; legal 1..3; bus_rdata is valid RD_LAT cycles after the cycle with bus_r=1.
- DMA_REG, 16'h4014, trigger address.
- OAM_PORT, 16'h2004, destination address.

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-low reset
- cpu_addr  input  16  core bus address
- cpu_r  input  1  core read strobe
- cpu_w  input  1  core write strobe
- cpu_wdata  input  8  core write data
- bus_rdata  input  8  read data from memory/IO decode
- bus_addr  output  16  arbitrated address to memory/IO decode
- bus_r  output  1  arbitrated read strobe
- bus_w  output  1  arbitrated write strobe
- bus_wdata  output  8  arbitrated write data
- cpu_halt  output  1  registered; 1 = core must stall and not advance its state
- dma_busy  output  1  registered; 1 while state != IDLE
- dma_done  output  1  registered one-cycle pulse after the last OAM write

Behaviour:
- Reset (RESET=0, async): state=IDLE, page=0, cnt=0, wait counter=0, parity=0, data latch=0, cpu_halt=0, dma_busy=0, dma_done=0.
- parity: a 1-bit free-running toggle every cycle from reset release.
- States: IDLE, HALT, ALIGN, READ, WAIT, WRITE.
- IDLE:
  - bus outputs pass the cpu_* inputs through combinationally.
  - Trigger: cpu_w=1 and cpu_addr==DMA_REG. On that edge, page<=cpu_wdata, cnt<=0, state<=HALT, cpu_halt<=1, dma_busy<=1.
  - The trigger write itself is forwarded to the bus unchanged. Downstream ignores it.
- Non-IDLE states: cpu_* inputs are ignored; bus_* is driven by the DMA engine.
- HALT: exactly 1 cycle, bus idle (r=w=0, addr=0, wdata=0). Lets the core settle.
  - Next state is ALIGN if parity==1 in this cycle, else READ.
- ALIGN: 1 cycle, bus idle, then READ.
- READ: 1 cycle; bus_addr={page,cnt}, bus_r=1.
  - RD_LAT==1: next state WRITE.
  - RD_LAT>1: next state WAIT, holding RD_LAT-1 cycles with the bus idle, then WRITE.
- Data capture: bus_rdata is sampled into the data latch on the edge ending the cycle RD_LAT-1 after READ. For RD_LAT=1 this is the READ edge.
- WRITE: 1 cycle; bus_addr=OAM_PORT, bus_w=1, bus_wdata=latched byte.
  - If cnt==8'hFF: state<=IDLE, cpu_halt<=0, dma_busy<=0, dma_done<=1.
  - Else: cnt<=cnt+1, state<=READ.
- Wrap: cnt is 8-bit, and the transfer ends on the write at cnt=FF. Address {page,FF}+1 is never read; no carry into page.
- Total cpu_halt high time with RD_LAT=1: 513 cycles (parity 0) or 514 (parity 1). In general: 1 + align + 256×(1+RD_LAT).
- dma_done is high for exactly one cycle, the first cycle with cpu_halt=0.
- A trigger in the same cycle as dma_done (state IDLE) starts a new transfer normally.
- Reset mid-transfer: immediate abort to the reset values, no further bus activity. OAM contents are undefined.
- bus_r and bus_w are never both 1.

Optional Feature:
- Macro OAM_DMA_ALIGN_EN.
- Defined: ALIGN state is present and used per parity as above (513/514 cycles).
- Undefined: ALIGN is removed and HALT always goes to READ. Transfer is fixed at 513 cycles (RD_LAT=1); the parity register may be omitted.

Test Plan:
- Passthrough: in IDLE, cpu_r=1, cpu_addr=16'h0123 -> bus_r=1, bus_addr=16'h0123 in the same cycle; cpu_halt=0.
- Basic DMA (RD_LAT=1, parity 0 at HALT): preload 0x0200..0x02FF with i^8'hA5, write 8'h02 to $4014 -> 256 alternating read 0x02nn / write $2004 with data nn^A5; cpu_halt high 513 cycles; dma_done one pulse; dma_busy falls with cpu_halt.
- Alignment (OAM_DMA_ALIGN_EN, parity 1 at HALT) -> one extra idle cycle, 514 halt cycles. With macro undefined -> 513 regardless of parity.
- Wrap: page 8'hFF -> last read 0xFFFF, then write, then IDLE; no access to 0x0000.
- RD_LAT=2 -> each byte takes 3 cycles (READ, WAIT, WRITE); correct data captured; halt 769/770 cycles.
- Reset mid-transfer: assert RESET low after the write of byte 8'h40 -> same-cycle cpu_halt=0, dma_busy=0, bus idle, no dma_done. A new $4014 write after release restarts from cnt=0.
